// File: rtl/i2c_uart_tx_bridge.sv
// Byte sink behind an I2C slave: queues decoded bytes in a small FIFO and
// serialises them onto a UART TX line as 8N1, LSB first.
module i2c_uart_tx_bridge #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic [7:0] i_DATA,
  input  logic       i_DV,
  output logic       o_TX,
  output logic       o_BUSY,
  output logic       o_FULL,
  output logic       o_OVERFLOW
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]      count_q, count_d;
  logic [1:0]         state_q, state_d;
  logic [BW-1:0]      baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               push, pop, baud_last;
  logic               tx_d, busy_d, full_d;

  // o_FULL is the registered start-of-cycle full flag, so a push while full
  // is dropped even if a pop frees a slot in the same cycle.
  assign push      = i_DV && !o_FULL;
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

  // Next-state, counter, shifter and output decode
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        if (baud_last) begin
          baud_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase

    count_d = count_q + CW'(push) - CW'(pop);
    full_d  = (count_d == CW'(DEPTH));
    busy_d  = (state_d != S_IDLE) || (count_d != '0);

    // Line level follows the state one cycle late, giving the fixed
    // two-cycle strobe-to-start-bit latency.
    unique case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State, counters, pointers and registered outputs
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      count_q    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_TX       <= 1'b1;
      o_BUSY     <= 1'b0;
      o_FULL     <= 1'b0;
      o_OVERFLOW <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      o_TX       <= tx_d;
      o_BUSY     <= busy_d;
      o_FULL     <= full_d;
      o_OVERFLOW <= i_DV && o_FULL;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge i_CLK) begin
    if (push) mem[wr_ptr] <= i_DATA;
  end

endmodule
